// File: rtl/sdram_slot_arbiter_pkg.sv
// sdram_slot_arbiter_pkg: slot state and grant encodings plus the byte-select helper
package sdram_slot_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ARB, S_WAIT} slot_state_t;
  typedef enum logic [1:0] {G_CPU, G_VID, G_TAPE, G_REF} grant_t;
  localparam logic [3:0] CNT_SAT = 4'd15;
  function automatic logic [7:0] byte_sel(input logic a0, input logic [15:0] d);
    return a0 ? d[15:8] : d[7:0];
  endfunction
endpackage

// File: rtl/sdram_slot_arbiter_edge_pend.sv
// sdram_slot_arbiter_edge_pend: rising-edge detector feeding a sticky pending flag cleared on grant
module sdram_slot_arbiter_edge_pend
  import sdram_slot_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_in,
  input  logic i_clr,
  output logic o_pend
);
  logic r_d, r_pend;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_d    <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_d    <= i_in;
      r_pend <= i_clr ? 1'b0 : (r_pend | (i_in & ~r_d));
    end
  end
  assign o_pend = r_pend;
endmodule

// File: rtl/sdram_slot_arbiter.sv
// sdram_slot_arbiter: per-clkref slot scheduler granting cpu, video, tape or refresh to the sdram core
module sdram_slot_arbiter
  import sdram_slot_arbiter_pkg::*;
#(
  parameter int AW          = 23,
  parameter int STARVE_MAX  = 4,
  parameter int REFRESH_MAX = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clkref,
  input  logic          cpu_oe,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  input  logic [AW-1:0] vid_addr,
  output logic [15:0]   vid_dout,
  input  logic          tape_rd,
  input  logic          tape_wr,
  input  logic [AW-1:0] tape_addr,
  input  logic [7:0]    tape_din,
  output logic [7:0]    tape_dout,
  output logic          tape_ack,
  output logic          mem_start,
  output logic          mem_refresh,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic          mem_done,
  input  logic [15:0]   mem_rdata
);
  localparam logic [3:0] L_STARVE = 4'(STARVE_MAX);
  localparam logic [3:0] L_REF    = 4'(REFRESH_MAX);
  slot_state_t   r_state, w_next;
  grant_t        r_grant, w_grant;
  logic          w_cpu_rd_p, w_cpu_wr_p, w_tape_rd_p, w_tape_wr_p;
  logic          w_clr_cpu, w_clr_tape, w_arb, w_done, w_tape_pend, w_vid_pend, w_clkref_rise;
  logic          r_clkref_d;
  logic [3:0]    r_starve, r_since_ref;
  logic [AW-2:0] r_vid_last, r_vid_word;
  logic [7:0]    r_cpu_dout, r_tape_dout, r_mem_din;
  logic [15:0]   r_vid_dout;
  logic          r_tape_ack, r_mem_start, r_mem_refresh, r_mem_we;
  logic [AW-1:0] r_mem_addr;

  sdram_slot_arbiter_edge_pend u_cpu_rd (.clk(clk), .reset_n(reset_n), .i_in(cpu_oe), .i_clr(w_clr_cpu), .o_pend(w_cpu_rd_p));
  sdram_slot_arbiter_edge_pend u_cpu_wr (.clk(clk), .reset_n(reset_n), .i_in(cpu_we), .i_clr(w_clr_cpu), .o_pend(w_cpu_wr_p));
  sdram_slot_arbiter_edge_pend u_tape_rd (.clk(clk), .reset_n(reset_n), .i_in(tape_rd), .i_clr(w_clr_tape), .o_pend(w_tape_rd_p));
  sdram_slot_arbiter_edge_pend u_tape_wr (.clk(clk), .reset_n(reset_n), .i_in(tape_wr), .i_clr(w_clr_tape), .o_pend(w_tape_wr_p));

  assign w_clkref_rise = clkref & ~r_clkref_d;
  assign w_tape_pend   = w_tape_rd_p | w_tape_wr_p;
  assign w_vid_pend    = vid_addr[AW-1:1] != r_vid_last;
  assign w_arb         = r_state == S_ARB;
  assign w_done        = r_state == S_WAIT && mem_done;
  assign w_clr_cpu     = w_arb && w_grant == G_CPU;
  assign w_clr_tape    = w_arb && w_grant == G_TAPE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_grant = G_REF;
    w_next  = (r_state == S_IDLE && w_clkref_rise) ? S_ARB :
              (r_state == S_ARB)                   ? S_WAIT :
              w_done                               ? S_IDLE : r_state;
    w_grant = (r_since_ref == L_REF)                ? G_REF  :
              (w_cpu_rd_p | w_cpu_wr_p)             ? G_CPU  :
              (w_tape_pend && r_starve == L_STARVE) ? G_TAPE :
              w_vid_pend                            ? G_VID  :
              w_tape_pend                           ? G_TAPE : G_REF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clkref_d    <= 1'b0;
      r_grant       <= G_REF;
      r_starve      <= '0;
      r_since_ref   <= '0;
      r_vid_last    <= '1;
      r_vid_word    <= '0;
      r_cpu_dout    <= '0;
      r_vid_dout    <= '0;
      r_tape_dout   <= '0;
      r_tape_ack    <= 1'b0;
      r_mem_start   <= 1'b0;
      r_mem_refresh <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_din     <= '0;
    end else begin
      r_clkref_d  <= clkref;
      r_mem_start <= w_arb;
      if (w_arb) begin
        r_grant       <= w_grant;
        r_mem_refresh <= w_grant == G_REF;
        r_mem_we      <= (w_grant == G_CPU && w_cpu_wr_p) || (w_grant == G_TAPE && w_tape_wr_p);
        r_mem_addr    <= w_grant == G_CPU  ? cpu_addr :
                         w_grant == G_VID  ? (vid_addr & {{(AW-1){1'b1}}, 1'b0}) :
                         w_grant == G_TAPE ? tape_addr : '0;
        r_mem_din     <= w_grant == G_CPU ? cpu_din : w_grant == G_TAPE ? tape_din : '0;
        r_vid_word    <= vid_addr[AW-1:1];
        r_starve      <= w_grant == G_TAPE ? 4'd0 :
                         (w_tape_pend && r_starve != CNT_SAT) ? r_starve + 4'd1 : r_starve;
        r_since_ref   <= w_grant == G_REF ? 4'd0 :
                         (r_since_ref != CNT_SAT) ? r_since_ref + 4'd1 : r_since_ref;
      end
      if (w_done && r_grant == G_CPU)
        r_cpu_dout <= r_mem_we ? r_mem_din : byte_sel(r_mem_addr[0], mem_rdata);
      if (w_done && r_grant == G_VID) begin
        r_vid_dout <= mem_rdata;
        r_vid_last <= r_vid_word;
      end
      if (w_done && r_grant == G_TAPE) begin
        r_tape_dout <= r_mem_we ? r_tape_dout : byte_sel(r_mem_addr[0], mem_rdata);
        r_tape_ack  <= ~r_tape_ack;
      end
    end
  end

  assign cpu_dout    = r_cpu_dout;
  assign vid_dout    = r_vid_dout;
  assign tape_dout   = r_tape_dout;
  assign tape_ack    = r_tape_ack;
  assign mem_start   = r_mem_start;
  assign mem_refresh = r_mem_refresh;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_din     = r_mem_din;
endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// tb_sdram_slot_arbiter: randomized slot-level checks of sdram_slot_arbiter against a behavioural model
module tb_sdram_slot_arbiter;
  localparam int AW = 23;
  localparam int STARVE_MAX = 4;
  localparam int REFRESH_MAX = 8;
  localparam int GC = 0, GV = 1, GT = 2, GR = 3;

  typedef struct packed {
    logic          ok;
    logic          rf;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic [7:0]    cd;
    logic [15:0]   vd;
    logic [7:0]    td;
    logic          ack;
  } snap_t;

  logic clk = 0;
  logic reset_n = 0, clkref = 0, cpu_oe = 0, cpu_we = 0, tape_rd = 0, tape_wr = 0;
  logic [AW-1:0] cpu_addr = '0, vid_addr = '0, tape_addr = '0;
  logic [7:0] cpu_din = '0, tape_din = '0;
  logic mem_done;
  logic [15:0] mem_rdata;
  logic [7:0] cpu_dout, tape_dout, mem_din;
  logic [15:0] vid_dout;
  logic tape_ack, mem_start, mem_refresh, mem_we;
  logic [AW-1:0] mem_addr;

  int n_checks = 0, n_fail = 0;
  logic [15:0] core_rdata = '0;

  logic m_crd, m_cwr, m_trd, m_twr, m_ack;
  logic [AW-2:0] m_vid_last;
  int m_starve, m_since;
  logic [7:0] m_cd, m_td;
  logic [15:0] m_vd;

  always #5 clk = ~clk;

  sdram_slot_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX), .REFRESH_MAX(REFRESH_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .clkref(clkref),
    .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .vid_addr(vid_addr), .vid_dout(vid_dout),
    .tape_rd(tape_rd), .tape_wr(tape_wr), .tape_addr(tape_addr), .tape_din(tape_din),
    .tape_dout(tape_dout), .tape_ack(tape_ack),
    .mem_start(mem_start), .mem_refresh(mem_refresh), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  // SDRAM core stand-in: answers each mem_start with a one-cycle mem_done two cycles later
  initial begin
    int lat;
    lat = 0;
    mem_done = 0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_done = 0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          mem_done = 1;
          mem_rdata = core_rdata;
        end
      end else if (mem_start) lat = 2;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset;
    {m_crd, m_cwr, m_trd, m_twr, m_ack} = '0;
    m_vid_last = '1;
    m_starve = 0;
    m_since = 0;
    m_cd = '0;
    m_td = '0;
    m_vd = '0;
  endtask

  // Slot outcome derived from the priority rules applied to the requests outstanding now
  task automatic model_step(input logic [15:0] rd, output snap_t e, output int g);
    logic tp, vp;
    tp = m_trd | m_twr;
    vp = vid_addr[AW-1:1] != m_vid_last;
    if (m_since == REFRESH_MAX) g = GR;
    else if (m_crd | m_cwr) g = GC;
    else if (tp && m_starve == STARVE_MAX) g = GT;
    else if (vp) g = GV;
    else if (tp) g = GT;
    else g = GR;
    e = '0;
    e.ok = 1;
    e.rf = (g == GR);
    if (g == GC) begin
      e.we = m_cwr;
      e.addr = cpu_addr;
      if (m_cwr) begin
        e.din = cpu_din;
        m_cd = cpu_din;
      end else m_cd = cpu_addr[0] ? rd[15:8] : rd[7:0];
      m_crd = 0;
      m_cwr = 0;
    end
    if (g == GV) begin
      e.addr = {vid_addr[AW-1:1], 1'b0};
      m_vd = rd;
      m_vid_last = vid_addr[AW-1:1];
    end
    if (g == GT) begin
      e.we = m_twr;
      e.addr = tape_addr;
      if (m_twr) e.din = tape_din;
      else m_td = tape_addr[0] ? rd[15:8] : rd[7:0];
      m_ack = ~m_ack;
      m_trd = 0;
      m_twr = 0;
    end
    m_starve = (g == GT) ? 0 : (tp && m_starve < 15) ? m_starve + 1 : m_starve;
    m_since = (g == GR) ? 0 : (m_since < 15) ? m_since + 1 : 15;
    e.cd = m_cd;
    e.vd = m_vd;
    e.td = m_td;
    e.ack = m_ack;
  endtask

  task automatic pulse(input logic [3:0] m);
    @(negedge clk);
    {tape_wr, tape_rd, cpu_we, cpu_oe} = m;
    @(negedge clk);
    {tape_wr, tape_rd, cpu_we, cpu_oe} = 4'b0;
    m_crd |= m[0];
    m_cwr |= m[1];
    m_trd |= m[2];
    m_twr |= m[3];
  endtask

  // One clkref period of 8 clocks; captures what was launched and the outputs after completion
  task automatic do_slot(input logic [15:0] rd, output snap_t o);
    int n;
    logic seen;
    core_rdata = rd;
    o = '0;
    seen = 0;
    n = 0;
    @(negedge clk);
    clkref = 1;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (mem_start) begin
        seen = 1;
        o.rf = mem_refresh;
        o.we = mem_we;
        o.addr = mem_refresh ? '0 : mem_addr;
        o.din = mem_we ? mem_din : '0;
      end
    end
    repeat (4) @(negedge clk);
    clkref = 0;
    repeat (2) @(negedge clk);
    o.ok = seen;
    o.cd = cpu_dout;
    o.vd = vid_dout;
    o.td = tape_dout;
    o.ack = tape_ack;
  endtask

  task automatic test_reset;
    logic saw;
    reset_n = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    model_reset();
    saw = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_start) saw = 1;
    end
    n_checks++;
    if ({cpu_dout, vid_dout, tape_dout} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_dout: got %h required 0", {cpu_dout, vid_dout, tape_dout});
    end
    n_checks++;
    if ({tape_ack, mem_refresh, mem_we} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000", {tape_ack, mem_refresh, mem_we});
    end
    n_checks++;
    if ({mem_addr, mem_din} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: got %h required 0", {mem_addr, mem_din});
    end
    n_checks++;
    if (saw !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_start: got %b required 0", saw);
    end
  endtask

  task automatic test_video_refresh;
    snap_t o, e;
    int g;
    logic [15:0] rd;
    vid_addr = 23'h000100;
    for (int s = 0; s < 4; s++) begin
      rd = 16'($urandom);
      model_step(rd, e, g);
      do_slot(rd, o);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL video_refresh slot %0d: got %h required %h", s, o, e);
      end
      n_checks++;
      if (s == 0 && {o.rf, o.addr, o.vd} !== {1'b0, 23'h000100, rd}) begin
        n_fail++;
        $display("FAIL video_first: got %h required %h", {o.rf, o.addr, o.vd}, {1'b0, 23'h000100, rd});
      end else if (s > 0 && o.rf !== 1'b1) begin
        n_fail++;
        $display("FAIL video_then_refresh slot %0d: got rf=%b required 1", s, o.rf);
      end
    end
  endtask

  task automatic test_cpu_priority;
    snap_t o, e;
    int g;
    logic [15:0] rd;
    vid_addr = 23'h000200;
    tape_addr = 23'h0ABCDE;
    pulse(4'b0100);
    cpu_addr = 23'h001235;
    pulse(4'b0001);
    for (int s = 0; s < 3; s++) begin
      rd = (s == 0) ? 16'hA53C : 16'($urandom);
      model_step(rd, e, g);
      do_slot(rd, o);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL cpu_priority slot %0d: got %h required %h", s, o, e);
      end
    end
    n_checks++;
    if (cpu_dout !== 8'hA5) begin
      n_fail++;
      $display("FAIL cpu_dout_high_byte: got %h required a5", cpu_dout);
    end
  endtask

  task automatic test_idle_slots;
    snap_t o, e;
    int g, k;
    logic [15:0] rd;
    k = 0;
    while (k < 8 && ((m_crd | m_cwr | m_trd | m_twr) || vid_addr[AW-1:1] != m_vid_last || m_since != 0)) begin
      rd = 16'($urandom);
      model_step(rd, e, g);
      do_slot(rd, o);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL idle slot %0d: got %h required %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_starve;
    snap_t o, e;
    int g, tape_slot, toggles;
    logic prev_ack;
    logic [15:0] rd;
    tape_addr = 23'h040001;
    pulse(4'b0100);
    tape_slot = 0;
    toggles = 0;
    prev_ack = tape_ack;
    for (int k = 1; k <= 5; k++) begin
      vid_addr = vid_addr + 23'd2;
      rd = 16'($urandom);
      model_step(rd, e, g);
      do_slot(rd, o);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL starve slot %0d: got %h required %h", k, o, e);
      end
      if (!o.rf && o.addr === tape_addr && tape_slot == 0) tape_slot = k;
      if (o.ack !== prev_ack) toggles++;
      prev_ack = o.ack;
    end
    n_checks++;
    if (tape_slot != 5) begin
      n_fail++;
      $display("FAIL starve_grant_slot: got %0d required 5", tape_slot);
    end
    n_checks++;
    if (toggles != 1) begin
      n_fail++;
      $display("FAIL starve_ack_toggles: got %0d required 1", toggles);
    end
  endtask

  task automatic test_refresh_force;
    snap_t o, e;
    int g;
    logic [15:0] rd;
    cpu_addr = 23'h000777;
    for (int s = 1; s <= 10; s++) begin
      if (s <= 9) pulse(4'b0001);
      rd = 16'($urandom);
      model_step(rd, e, g);
      do_slot(rd, o);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL refresh_force slot %0d: got %h required %h", s, o, e);
      end
      if (s == 9) begin
        n_checks++;
        if (o.rf !== 1'b1) begin
          n_fail++;
          $display("FAIL forced_refresh_slot9: got rf=%b required 1", o.rf);
        end
      end
      if (s == 10) begin
        n_checks++;
        if ({o.rf, o.addr} !== {1'b0, 23'h000777}) begin
          n_fail++;
          $display("FAIL cpu_after_refresh_slot10: got %h required %h", {o.rf, o.addr}, {1'b0, 23'h000777});
        end
      end
    end
  endtask

  task automatic test_tape_simul;
    snap_t o, e;
    int g;
    logic ack0;
    logic [15:0] rd;
    tape_din = 8'h3C;
    tape_addr = 23'h000050;
    ack0 = tape_ack;
    pulse(4'b1100);
    for (int s = 0; s < 2; s++) begin
      rd = 16'($urandom);
      model_step(rd, e, g);
      do_slot(rd, o);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL tape_simul slot %0d: got %h required %h", s, o, e);
      end
      if (s == 0) begin
        n_checks++;
        if ({o.we, o.din, o.addr} !== {1'b1, 8'h3C, 23'h000050}) begin
          n_fail++;
          $display("FAIL tape_simul_write: got %h required %h", {o.we, o.din, o.addr}, {1'b1, 8'h3C, 23'h000050});
        end
      end
    end
    n_checks++;
    if (tape_ack !== ~ack0) begin
      n_fail++;
      $display("FAIL tape_simul_single_ack: got %b required %b", tape_ack, ~ack0);
    end
  endtask

  task automatic test_random;
    snap_t o, e;
    int g;
    logic [15:0] rd;
    logic [3:0] m;
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(2) == 0) vid_addr = 23'($urandom);
      cpu_addr = 23'($urandom);
      cpu_din = 8'($urandom);
      tape_addr = 23'($urandom);
      tape_din = 8'($urandom);
      m = 4'($urandom) & 4'($urandom);
      if (m != 0) pulse(m);
      rd = 16'($urandom);
      model_step(rd, e, g);
      do_slot(rd, o);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random slot %0d: got %h required %h", s, o, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    snap_t o, e;
    int g, n;
    logic seen, saw;
    logic [15:0] rd;
    tape_addr = 23'h000123;
    pulse(4'b0100);
    core_rdata = 16'h5AA5;
    @(negedge clk);
    clkref = 1;
    seen = 0;
    n = 0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (mem_start) seen = 1;
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_start: got %b required 1", seen);
    end
    #1;
    reset_n = 0;
    clkref = 0;
    @(negedge clk);
    reset_n = 1;
    saw = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_start) saw = 1;
    end
    model_reset();
    n_checks++;
    if ({cpu_dout, vid_dout, tape_dout, tape_ack, mem_refresh, mem_we, mem_addr, mem_din, saw} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h required 0",
               {cpu_dout, vid_dout, tape_dout, tape_ack, mem_refresh, mem_we, mem_addr, mem_din, saw});
    end
    vid_addr = 23'h000300;
    rd = 16'($urandom);
    model_step(rd, e, g);
    do_slot(rd, o);
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_mid_next_slot: got %h required %h", o, e);
    end
    n_checks++;
    if ({o.rf, o.addr} !== {1'b0, 23'h000300}) begin
      n_fail++;
      $display("FAIL reset_mid_video_refill: got %h required %h", {o.rf, o.addr}, {1'b0, 23'h000300});
    end
  endtask

  initial begin
    test_reset;
    test_video_refresh;
    test_cpu_priority;
    test_idle_slots;
    test_starve;
    test_idle_slots;
    test_refresh_force;
    test_idle_slots;
    test_tape_simul;
    test_random;
    test_idle_slots;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
